serial_sub_ctrl: RTL and testbench

- Bit-serial subtractor controller.
- Sequences one full-subtractor bit cell (diff = a^b^bin, bout = ~a&b | ~a&bin | b&bin) across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Provides a start/busy/done handshake so a datapath can request multi-bit subtraction with a single 1-bit cell plus a borrow flop.
- Trades latency for area next to the combinational subtractor blocks.

---
 rtl/serial_sub_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_diff;
  logic             cell_bout;

  function automatic logic fs_diff(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic c);
    return (~x & y) | (~x & c) | (y & c);
  endfunction

  // Single shared subtractor cell working on the current LSBs
  always_comb begin
    cell_diff = fs_diff(sa[0], sb[0], brw);
    cell_bout = fs_borrow(sa[0], sb[0], brw);
    last      = (cnt == CW'(WIDTH - 1));
  end

  // Next-state logic; start is only honoured when no operation is in flight
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, serial shifting and result load on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      brw <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= {cell_diff, res[WIDTH-1:1]};
      brw <= cell_bout;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff <= {cell_diff, res[WIDTH-1:1]};
        bout <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
        // brw still holds the borrow into the MSB cell here
        ovf  <= brw ^ cell_bout;
`endif
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl; expected results are queued at start and
// popped when done pulses. Define SERIAL_SUB_OVF_EN to also cover ovf.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sbq[$];
  exp_t prev;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t       e;
    logic [W:0] t;
    int         s;
    t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    e.d  = t[W-1:0];
    e.bo = t[W];
    s    = int'($signed(x)) - int'($signed(y)) - int'({31'd0, c});
    e.ov = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    return e;
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a     = x;
    b     = y;
    bin   = c;
    start = 1'b1;
    prev  = model(x, y, c);
    sbq.push_back(prev);
  endtask

  // Counts cycles from the accepting edge to the done pulse, and busy cycles
  task automatic wait_done(input string tag, input bit hold);
    int n    = 0;
    int nb   = 0;
    bit seen = 1'b0;
    while (n < 30 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1 && !hold) start = 1'b0;
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'd9);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  initial begin
    int n;
    int dn;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    start_op(8'h05, 8'h03, 1'b0);
    wait_done("sub_5_3", 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("diff_held_idle", 32'(diff), 32'h02);

    start_op(8'h03, 8'h05, 1'b0);
    wait_done("sub_3_5", 1'b0);
    @(negedge clk);
    start_op(8'h00, 8'h00, 1'b1);
    wait_done("sub_0_0_bin", 1'b0);
    @(negedge clk);

`ifdef SERIAL_SUB_OVF_EN
    start_op(8'h80, 8'h01, 1'b0);
    wait_done("ovf_80_01", 1'b0);
    @(negedge clk);
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done("ovf_7f_01", 1'b0);
    @(negedge clk);
`endif

    // start while busy must be ignored, and the old result held meanwhile
    begin
      logic [W-1:0] held;
      held = prev.d;
      start_op(8'h10, 8'h01, 1'b0);
      n = 0;
      dn = 0;
      repeat (5) begin
        @(negedge clk);
        n++;
        if (n == 1) start = 1'b0;
        if (n == 3) begin
          check("diff_held_run", 32'(diff), 32'(held));
          start = 1'b1;
          a     = 8'hFF;
          b     = 8'hFF;
        end
        if (n == 4) begin
          a = 8'hA5;
          b = 8'h5A;
        end
        if (n == 5) start = 1'b0;
      end
      while (n < 30 && dn == 0) begin
        @(negedge clk);
        n++;
        if (done) dn = 1;
      end
      check("ignore_latency", 32'(n), 32'd9);
    end
    @(negedge clk);

    // start held high: back-to-back operations, busy low only in DONE
    start_op(8'h05, 8'h03, 1'b0);
    wait_done("cont0", 1'b1);
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(model(8'h05, 8'h03, 1'b0));
      wait_done("cont", 1'b1);
    end
    start = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of RUN
    start_op(8'h37, 8'h12, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    check("pre_abort_diff", 32'(diff), 32'h02);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no_done_after_abort", 32'(dn), 32'd0);
    start_op(8'h37, 8'h12, 1'b0);
    wait_done("post_reset", 1'b0);
    @(negedge clk);
    check("queue_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
